// File: rtl/alu_seq_pkg.sv
// Shared constants and enums for the ALU operation sequencer: class codes,
// R-type function codes, internal operation set and sequencer states.
package alu_seq_pkg;

  localparam logic [5:0] ALUOP_RTYPE = 6'd0;
  localparam logic [5:0] ALUOP_ADDI  = 6'd1;
  localparam logic [5:0] ALUOP_SLTIU = 6'd2;
  localparam logic [5:0] ALUOP_ORI   = 6'd3;
  localparam logic [5:0] ALUOP_LW    = 6'd4;
  localparam logic [5:0] ALUOP_SW    = 6'd5;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;
  localparam logic [5:0] FUNCT_MUL  = 6'b011000;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLT,
    OP_SLTU,
    OP_SRA,
    OP_SRAV,
    OP_MUL
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_HOLD
  } seq_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of class code and function code into an internal
// operation; anything unrecognised decodes to OP_NONE and flags illegal.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [5:0] aluop_i,
  input  logic [5:0] funct_i,
  output alu_op_e    op_o,
  output logic       illegal_o
);

  always_comb begin
    op_o = OP_NONE;
    unique case (aluop_i)
      ALUOP_RTYPE: begin
        unique case (funct_i)
          FUNCT_ADD:  op_o = OP_ADD;
          FUNCT_SUB:  op_o = OP_SUB;
          FUNCT_AND:  op_o = OP_AND;
          FUNCT_OR:   op_o = OP_OR;
          FUNCT_SLT:  op_o = OP_SLT;
          FUNCT_SRA:  op_o = OP_SRA;
          FUNCT_SRAV: op_o = OP_SRAV;
          FUNCT_MUL:  op_o = OP_MUL;
          default:    op_o = OP_NONE;
        endcase
      end
      ALUOP_ADDI, ALUOP_LW, ALUOP_SW: op_o = OP_ADD;
      ALUOP_SLTIU:                    op_o = OP_SLTU;
      ALUOP_ORI:                      op_o = OP_OR;
      default:                        op_o = OP_NONE;
    endcase
  end

  assign illegal_o = (op_o == OP_NONE);

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU sequencer: single-cycle ops register in one cycle, MUL runs a radix-2
// shift-add over DATA_W cycles; results are held until the consumer takes them.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SH_W   = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [5:0]        aluop_i,
  input  logic [5:0]        funct_i,
  input  logic [SH_W-1:0]   shamt_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              illegal_o,
  output logic              busy_o
);

  seq_state_e        state_q, state_d;
  alu_op_e           dec_op;
  logic              dec_illegal;
  logic              accept;
  logic [DATA_W-1:0] alu_res;

  logic [DATA_W-1:0] mul_a_q, mul_b_q, mul_acc_q, mul_add;
  logic [SH_W-1:0]   cnt_q;

  logic [DATA_W-1:0] result_q;
  logic              zero_q, illegal_q, out_valid_q;

  alu_op_decode u_decode (
    .aluop_i   (aluop_i),
    .funct_i   (funct_i),
    .op_o      (dec_op),
    .illegal_o (dec_illegal)
  );

  assign accept = in_valid_i && in_ready_o;

  always_comb begin
    alu_res = '0;
    unique case (dec_op)
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_SUB:  alu_res = src1_i - src2_i;
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_SLT:  alu_res[0] = ($signed(src1_i) < $signed(src2_i));
      OP_SLTU: alu_res[0] = (src1_i < src2_i);
      OP_SRA:  alu_res = $signed(src2_i) >>> shamt_i;
      OP_SRAV: alu_res = $signed(src2_i) >>> src1_i[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  // Low DATA_W bits of the two's-complement product equal those of the
  // unsigned product, so a plain unsigned shift-add suffices.
  assign mul_add = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A draining HOLD behaves like IDLE so single-cycle ops can issue back-to-back.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = (dec_op == OP_MUL) ? ST_MUL : ST_HOLD;
      ST_MUL:  if (cnt_q == '0) state_d = ST_HOLD;
      ST_HOLD: begin
        if (accept)           state_d = (dec_op == OP_MUL) ? ST_MUL : ST_HOLD;
        else if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready_i);
    busy_o     = (state_q == ST_MUL);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_acc_q   <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      if (dec_op == OP_MUL) begin
        mul_a_q     <= src1_i;
        mul_b_q     <= src2_i;
        mul_acc_q   <= '0;
        cnt_q       <= SH_W'(DATA_W - 1);
        out_valid_q <= 1'b0;
      end else begin
        result_q    <= alu_res;
        zero_q      <= (alu_res == '0);
        illegal_q   <= dec_illegal;
        out_valid_q <= 1'b1;
      end
    end else if (state_q == ST_MUL) begin
      mul_acc_q <= mul_add;
      mul_a_q   <= mul_a_q << 1;
      mul_b_q   <= mul_b_q >> 1;
      if (cnt_q == '0) begin
        result_q    <= mul_add;
        zero_q      <= (mul_add == '0);
        illegal_q   <= 1'b0;
        out_valid_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - SH_W'(1);
      end
    end else if ((state_q == ST_HOLD) && out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign illegal_o   = illegal_q;
  assign out_valid_o = out_valid_q;

endmodule
